// File: rtl/shift_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_arbiter
// Purpose  : Shares one 32-bit barrel shifter (SLL/SRL/SRA) between two
//            valid/ready requesters. Arbitration is either round-robin or
//            fixed priority (requester 0 wins). The result sits in a
//            single-entry output register that stalls under backpressure.
// Ports    : clk                   - rising-edge clock
//            reset                 - asynchronous, active-low reset
//            reqN_valid/ready      - request handshake, N = 0,1
//            reqN_a                - shift amount (bits [4:0] used)
//            reqN_b                - data operand
//            reqN_op               - 00 SLL, 01 SRL, 11 SRA, 10 zero
//            reqN_tag              - opaque tag returned with the result
//            res_valid/ready       - result handshake
//            res_data/src/tag      - shift result, issuing requester, tag
// Revision : 1.0 - initial release
// ============================================================================
module shift_unit_arbiter #(
    parameter int TAG_W = 4,
    parameter bit RR    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [1:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [1:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b11;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               ptr;        // index of the last granted requester
    logic               grant0;
    logic               grant1;
    logic               slot_free;
    logic               handshake;
    logic               sel;
    logic [4:0]         sh;
    logic [31:0]        op_b;
    logic [1:0]         op;
    logic [TAG_W-1:0]   tag;
    logic [31:0]        shift_res;
    logic               unused_hi_bits;

    // Only the low five bits of the amount operands matter.
    assign unused_hi_bits = ^{req0_a[31:5], req1_a[31:5]};

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && !req1_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid && !req0_valid) begin
            grant1 = 1'b1;
        end else if (req0_valid && req1_valid) begin
            if (RR) begin
                // Grant whichever requester did not win last time.
                grant0 = ptr;
                grant1 = !ptr;
            end else begin
                grant0 = 1'b1;
            end
        end
    end

    assign res_valid  = (state == FULL);
    assign slot_free  = !res_valid || res_ready;

    // Gated by reset so nothing is accepted while reset is held.
    assign req0_ready = reset && slot_free && grant0;
    assign req1_ready = reset && slot_free && grant1;
    assign handshake  = req0_ready || req1_ready;

    // ------------------------------------------------------------------
    // Operand mux and shifter
    // ------------------------------------------------------------------
    assign sel  = grant1;
    assign sh   = sel ? req1_a[4:0] : req0_a[4:0];
    assign op_b = sel ? req1_b      : req0_b;
    assign op   = sel ? req1_op     : req0_op;
    assign tag  = sel ? req1_tag    : req0_tag;

    always_comb begin
        shift_res = 32'd0;
        case (op)
            OP_SLL:  shift_res = op_b << sh;
            OP_SRL:  shift_res = op_b >> sh;
            OP_SRA:  shift_res = $unsigned($signed(op_b) >>> sh);
            default: shift_res = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output-slot FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (handshake) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                // Drain with no refill empties the slot; otherwise it stays
                // full (either stalled or drained-and-refilled).
                if (res_ready && !handshake) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register and last-grant pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_data <= 32'd0;
            res_src  <= 1'b0;
            res_tag  <= '0;
            ptr      <= 1'b1;
        end else if (handshake) begin
            res_data <= shift_res;
            res_src  <= sel;
            res_tag  <= tag;
            ptr      <= sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit_arbiter
// Purpose  : Directed self-checking bench for shift_unit_arbiter. One
//            round-robin instance carries most vectors; a fixed-priority
//            instance with its own inputs covers the RR=0 ordering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_unit_arbiter;

    localparam int TAG_W = 4;

    logic             clk;
    logic             reset;

    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [1:0]       req0_op, req1_op;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             res_valid, res_ready, res_src;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;

    logic             fp_req0_valid, fp_req0_ready, fp_req1_valid, fp_req1_ready;
    logic [31:0]      fp_req0_a, fp_req0_b, fp_req1_a, fp_req1_b;
    logic [1:0]       fp_req0_op, fp_req1_op;
    logic [TAG_W-1:0] fp_req0_tag, fp_req1_tag;
    logic             fp_res_valid, fp_res_ready, fp_res_src;
    logic [31:0]      fp_res_data;
    logic [TAG_W-1:0] fp_res_tag;

    int checks = 0;
    int errors = 0;

    shift_unit_arbiter #(.TAG_W(TAG_W), .RR(1'b1)) dut_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_src(res_src), .res_tag(res_tag)
    );

    shift_unit_arbiter #(.TAG_W(TAG_W), .RR(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_a(fp_req0_a),
        .req0_b(fp_req0_b), .req0_op(fp_req0_op), .req0_tag(fp_req0_tag),
        .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_a(fp_req1_a),
        .req1_b(fp_req1_b), .req1_op(fp_req1_op), .req1_tag(fp_req1_tag),
        .res_valid(fp_res_valid), .res_ready(fp_res_ready), .res_data(fp_res_data),
        .res_src(fp_res_src), .res_tag(fp_res_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single requester-0 operation into a free slot, result checked next cycle.
    task automatic op0(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [31:0] exp);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; req0_tag = 4'hA;
        #1;
        chk({name, "_ready"}, {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        chk({name, "_data"}, res_data, exp);
    endtask

    initial begin
        reset = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; req0_tag = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; req1_tag = 0;
        res_ready = 1'b1;
        fp_req0_valid = 0; fp_req0_a = 0; fp_req0_b = 0; fp_req0_op = 0; fp_req0_tag = 0;
        fp_req1_valid = 0; fp_req1_a = 0; fp_req1_b = 0; fp_req1_op = 0; fp_req1_tag = 0;
        fp_res_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_data",  res_data, 32'd0);
        chk("rst_src",   {31'd0, res_src}, 32'd0);
        chk("rst_tag",   {28'd0, res_tag}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // ---------------- 1. basic SLL ----------------
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'h1; req0_op = 2'b00; req0_tag = 4'd5;
        #1;
        chk("sll_ready0", {31'd0, req0_ready}, 32'd1);
        chk("sll_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        chk("sll_valid", {31'd0, res_valid}, 32'd1);
        chk("sll_data",  res_data, 32'h8);
        chk("sll_src",   {31'd0, res_src}, 32'd0);
        chk("sll_tag",   {28'd0, res_tag}, 32'd5);

        // ---------------- 2. SRA / SRL on requester 1 ----------------
        req1_valid = 1'b1; req1_a = 32'd99; req1_b = 32'hFFFFB57B; req1_op = 2'b11; req1_tag = 4'd3;
        #1;
        chk("sra_ready1", {31'd0, req1_ready}, 32'd1);
        step();
        chk("sra_data", res_data, 32'hFFFFF6AF);
        chk("sra_src",  {31'd0, res_src}, 32'd1);
        req1_op = 2'b01; req1_tag = 4'd4;
        #1;
        chk("srl_ready1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        chk("srl_data", res_data, 32'h1FFFF6AF);
        chk("srl_tag",  {28'd0, res_tag}, 32'd4);
        step();
        chk("drain_empty", {31'd0, res_valid}, 32'd0);
        chk("drain_hold",  res_data, 32'h1FFFF6AF);

        // ---------------- 3. round-robin vs fixed priority ----------------
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'h1;   req0_op = 2'b00; req0_tag = 4'd1;
        req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'h100; req1_op = 2'b01; req1_tag = 4'd2;
        fp_req0_valid = 1'b1; fp_req0_a = 32'd1; fp_req0_b = 32'h1; fp_req0_tag = 4'd1;
        fp_req1_valid = 1'b1; fp_req1_a = 32'd2; fp_req1_b = 32'h1; fp_req1_tag = 4'd2;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rr_valid%0d", i), {31'd0, res_valid}, 32'd1);
            chk($sformatf("rr_src%0d", i),   {31'd0, res_src}, i % 2);
            chk($sformatf("rr_data%0d", i),  res_data, (i % 2) ? 32'h10 : 32'h2);
            chk($sformatf("fp_src%0d", i),   {31'd0, fp_res_src}, 32'd0);
            chk($sformatf("fp_rdy1_%0d", i), {31'd0, fp_req1_ready}, 32'd0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
        step();
        chk("rr_empty", {31'd0, res_valid}, 32'd0);

        // ---------------- 4. backpressure ----------------
        // Pointer last pointed at requester 1, so requester 0 goes first.
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'h3; req0_op = 2'b00; req0_tag = 4'd7;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'h80000000; req1_op = 2'b11; req1_tag = 4'd9;
        #1;
        chk("bp_first_rdy0", {31'd0, req0_ready}, 32'd1);
        step();
        res_ready = 1'b0;
        req0_a = 32'd0; req0_b = 32'h5; req0_tag = 4'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_rdy0_%0d", i), {31'd0, req0_ready}, 32'd0);
            chk($sformatf("bp_rdy1_%0d", i), {31'd0, req1_ready}, 32'd0);
            step();
            chk($sformatf("bp_data%0d", i), res_data, 32'hC);
            chk($sformatf("bp_tag%0d", i),  {28'd0, res_tag}, 32'd7);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_rel_rdy1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        chk("bp_r1_data", res_data, 32'hC0000000);
        chk("bp_r1_tag",  {28'd0, res_tag}, 32'd9);
        chk("bp_r1_src",  {31'd0, res_src}, 32'd1);
        step();
        req0_valid = 1'b0;
        chk("bp_r0_valid", {31'd0, res_valid}, 32'd1);
        chk("bp_r0_data",  res_data, 32'h5);
        chk("bp_r0_tag",   {28'd0, res_tag}, 32'd8);
        step();

        // ---------------- 5. edge operands ----------------
        op0("zero_op",   32'd0,  32'hFFFFFFFF, 2'b10, 32'h0);
        op0("sh0_sra",   32'd32, 32'h80000000, 2'b11, 32'h80000000);
        op0("sll31",     32'd31, 32'h1,        2'b00, 32'h80000000);
        step();

        // ---------------- 6. reset mid-operation ----------------
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'h1; req0_op = 2'b00; req0_tag = 4'd2;
        step();
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'h4; req1_op = 2'b01; req1_tag = 4'd6;
        chk("mid_full", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_async_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_async_data",  res_data, 32'd0);
        chk("mid_rst_rdy0",    {31'd0, req0_ready}, 32'd0);
        chk("mid_rst_rdy1",    {31'd0, req1_ready}, 32'd0);
        res_ready = 1'b1;
        step();
        chk("mid_rst_hold", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("post_rdy1", {31'd0, req1_ready}, 32'd0);
        step();
        chk("post_src",  {31'd0, res_src}, 32'd0);
        chk("post_data", res_data, 32'h2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
